// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the multicycle RV32I control path
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLTU = 4'b1000,
    ALU_BGEU = 4'b1001,
    ALU_SLL  = 4'b1010,
    ALU_SRL  = 4'b1011,
    ALU_SRA  = 4'b1100,
    ALU_SLT  = 4'b1101,
    ALU_BGE  = 4'b1110
  } alu_op_t;

  // Which funct3 table the ALU op decoder applies in the current state
  typedef enum logic [1:0] {
    CLS_ADD    = 2'b00,
    CLS_R      = 2'b01,
    CLS_I      = 2'b10,
    CLS_BRANCH = 2'b11
  } alu_class_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRADR  = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14
  } ctrl_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - funct3/funct7[5]/class to ALU operation code
module alu_op_decoder
  import cpu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  alu_class_t op_class_i,
  output alu_op_t    alu_op_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    case (op_class_i)
      CLS_BRANCH: begin
        case (funct3_i)
          3'b000, 3'b001: alu_op_o = ALU_SUB;
          3'b100:         alu_op_o = ALU_SLT;
          3'b101:         alu_op_o = ALU_BGE;
          3'b110:         alu_op_o = ALU_SLTU;
          3'b111:         alu_op_o = ALU_BGEU;
          default:        alu_op_o = ALU_SUB;
        endcase
      end
      CLS_R, CLS_I: begin
        case (funct3_i)
          // funct7[5] on an immediate add is part of the immediate, not a SUB
          3'b000:  alu_op_o = (op_class_i == CLS_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op_o = ALU_SLL;
          3'b010:  alu_op_o = ALU_SLT;
          3'b011:  alu_op_o = ALU_SLTU;
          3'b100:  alu_op_o = ALU_XOR;
          3'b101:  alu_op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op_o = ALU_OR;
          default: alu_op_o = ALU_AND;
        endcase
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - main sequencing FSM of the multicycle RV32I core
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        MemValid,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControlSignal,
  output logic        IllegalInstr
);

  // The value 0 is reserved; both settings start the core in FETCH
  localparam ctrl_state_t RST_STATE = (RESET_STATE_FETCH == 0) ? S_FETCH : S_FETCH;

  ctrl_state_t state_q, state_d;
  alu_class_t  op_class;
  alu_op_t     alu_dec;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_store;
  logic        branch_taken;
  logic        unused_instr_bits;

  assign opcode            = Instr[6:0];
  assign funct3            = Instr[14:12];
  assign is_store          = Instr[5];
  assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    op_class = CLS_ADD;
    case (state_q)
      S_EXECR:  op_class = CLS_R;
      S_EXECI:  op_class = CLS_I;
      S_BRANCH: op_class = CLS_BRANCH;
      default:  op_class = CLS_ADD;
    endcase
  end

  alu_op_decoder u_alu_op_decoder (
    .funct3_i   (funct3),
    .funct7b5_i (Instr[30]),
    .op_class_i (op_class),
    .alu_op_o   (alu_dec)
  );

  // BEQ is taken on Zero; every other comparison is taken on a nonzero ALU result
  always_comb begin
    case (funct3)
      3'b000:                         branch_taken = Zero;
      3'b001, 3'b100, 3'b101,
      3'b110, 3'b111:                 branch_taken = ~Zero;
      default:                        branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    MemValid         = 1'b0;
    MemWrite         = 1'b0;
    AdrSrc           = ADR_PC;
    IRWrite          = 1'b0;
    PCWrite          = 1'b0;
    RegWrite         = 1'b0;
    ResultSrc        = RES_ALUOUT;
    ALUSrcA          = SRCA_PC;
    ALUSrcB          = SRCB_RD2;
    ImmSrc           = IMM_I;
    ALUControlSignal = alu_dec;
    IllegalInstr     = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemValid  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target is precomputed here and held in ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (opcode == OP_BRANCH)   ImmSrc = IMM_B;
        else if (opcode == OP_JAL) ImmSrc = IMM_J;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALRADR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            IllegalInstr = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = is_store ? IMM_S : IMM_I;
        state_d = is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemValid = 1'b1;
        AdrSrc   = ADR_ALUOUT;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        MemValid = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = ADR_ALUOUT;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        ImmSrc  = IMM_B;
        PCWrite = branch_taken;
        state_d = S_FETCH;
      end
      S_JAL, S_JALR: begin
        // PC takes the target from ALUOut while the ALU forms the link value
        PCWrite = 1'b1;
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        state_d = S_ALUWB;
      end
      S_JALRADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = S_JALR;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    if (!rst_n) begin
      MemValid         = 1'b0;
      MemWrite         = 1'b0;
      AdrSrc           = 1'b0;
      IRWrite          = 1'b0;
      PCWrite          = 1'b0;
      RegWrite         = 1'b0;
      ResultSrc        = 2'b00;
      ALUSrcA          = 2'b00;
      ALUSrcB          = 2'b00;
      ImmSrc           = 3'b000;
      ALUControlSignal = 4'b0000;
      IllegalInstr     = 1'b0;
    end
  end

endmodule
